// File: rtl/op_differentiator_mc.sv
// op_differentiator_mc: time-multiplexed, multi-channel ORDER-th backward-difference filter.
// Define OP_DIFF_SAT_EN to clamp every stage subtraction; otherwise stages wrap modulo 2^WIDTH.
module op_differentiator_mc #(
    parameter int WIDTH  = 19,
    parameter int ORDER  = 3,
    parameter int NUM_CH = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    lr_clk,
    input  logic                    hist_clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    output logic [CH_W-1:0]         out_ch
);

    localparam int CNT_W  = $clog2(NUM_CH + 1);
    localparam int STEP_W = (ORDER > 1) ? $clog2(ORDER) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_OUT
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CH_W-1:0]         ch_q;
    logic [STEP_W-1:0]       step_q;
    logic signed [WIDTH-1:0] acc_q;
    logic signed [WIDTH-1:0] hist_q [NUM_CH][ORDER];
    logic                    lr_prev_q;
    logic                    clr_pend_q;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]         out_ch_q;

    logic                    lr_rise_d;
    logic                    accept_d;
    logic signed [WIDTH-1:0] diff_d;

    // One stage of the difference chain: a - b, wrapped or clamped to WIDTH bits.
    function automatic logic signed [WIDTH-1:0] stage_sub(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
`ifdef OP_DIFF_SAT_EN
        logic [WIDTH:0] wide;
        // NOTE: blocking '=' is correct here: function locals are combinational temporaries.
        wide = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        if (wide[WIDTH] != wide[WIDTH-1]) begin
            return wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return wide[WIDTH-1:0];
`else
        return a - b;
`endif
    endfunction

    // A frame edge blocks acceptance in its own cycle so the sample lands on channel 0.
    assign lr_rise_d = lr_clk & ~lr_prev_q;
    assign in_ready  = (state_q == S_IDLE) && (cnt_q < CNT_W'(NUM_CH)) && !lr_rise_d;
    assign accept_d  = in_valid & in_ready;
    assign diff_d    = stage_sub(acc_q, hist_q[ch_q][step_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ch_q        <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            lr_prev_q   <= 1'b0;
            clr_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            // NOTE: history is a plain register array, not a RAM, so it is reset with the rest of the state.
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < ORDER; k++) begin
                    hist_q[c][k] <= '0;
                end
            end
        end else begin
            lr_prev_q   <= lr_clk;
            out_valid_q <= 1'b0;

            if (lr_rise_d) begin
                cnt_q <= '0;
            end else if (accept_d) begin
                cnt_q <= cnt_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        ch_q    <= cnt_q[CH_W-1:0];
                        acc_q   <= in_data;
                        step_q  <= '0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    // acc_q holds d_{k-1}; it becomes the new h[c][k-1] as d_k is latched.
                    hist_q[ch_q][step_q] <= acc_q;
                    acc_q                <= diff_d;
                    step_q               <= step_q + 1'b1;
                    if (step_q == STEP_W'(ORDER - 1)) begin
                        state_q <= S_OUT;
                    end
                end
                S_OUT: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= acc_q;
                    out_ch_q    <= ch_q;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // A clear seen during CALC is deferred so the in-flight sample uses its old history.
            if (state_q == S_CALC) begin
                if (hist_clr) begin
                    clr_pend_q <= 1'b1;
                end
            end else if (hist_clr || clr_pend_q) begin
                clr_pend_q <= 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    for (int k = 0; k < ORDER; k++) begin
                        hist_q[c][k] <= '0;
                    end
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_op_differentiator_mc.sv
// Self-checking bench for op_differentiator_mc (default parameters) with a scoreboard queue.
// Expected values come from directed constants or a per-channel difference model.
module tb_op_differentiator_mc;

    localparam int WIDTH  = 19;
    localparam int ORDER  = 3;
    localparam int NUM_CH = 16;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef OP_DIFF_SAT_EN
    localparam int MAXV   = (1 << (WIDTH - 1)) - 1;
    localparam int MINV   = -(1 << (WIDTH - 1));
    localparam int SAT2   = -262144;
`else
    localparam int SAT2   = 3;
`endif

    logic                    clk      = 1'b0;
    logic                    rst_n    = 1'b1;
    logic                    lr_clk   = 1'b0;
    logic                    hist_clr = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [WIDTH-1:0] in_data  = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_data;
    logic [CH_W-1:0]         out_ch;

    typedef struct {
        int    ch;
        int    data;
        int    cyc;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   exp_ch = 0;
    int   mh [NUM_CH][ORDER];

    op_differentiator_mc #(
        .WIDTH (WIDTH),
        .ORDER (ORDER),
        .NUM_CH(NUM_CH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lr_clk   (lr_clk),
        .hist_clr (hist_clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ch   (out_ch)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sub_m(input int a, input int b);
        int w;
        w = a - b;
`ifdef OP_DIFF_SAT_EN
        if (w > MAXV) w = MAXV;
        if (w < MINV) w = MINV;
`else
        w = (w <<< (32 - WIDTH)) >>> (32 - WIDTH);
`endif
        return w;
    endfunction

    function automatic int model(input int ch, input int x);
        int d;
        int nd;
        d = x;
        for (int k = 0; k < ORDER; k++) begin
            nd = sub_m(d, mh[ch][k]);
            mh[ch][k] = d;
            d = nd;
        end
        return d;
    endfunction

    task automatic zero_model();
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < ORDER; k++)
                mh[c][k] = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_data"}, int'(out_data), e.data);
                check({e.tag, "_ch"}, int'(out_ch), e.ch);
                check({e.tag, "_lat"}, cyc, e.cyc);
            end
        end
    end

    task automatic frame();
        @(negedge clk);
        lr_clk = 1'b1;
        @(negedge clk);
        lr_clk = 1'b0;
        exp_ch = 0;
    endtask

    task automatic clear_hist();
        @(negedge clk);
        hist_clr = 1'b1;
        @(negedge clk);
        hist_clr = 1'b0;
        zero_model();
    endtask

    // Offer one sample; on accept, push the expected result. Returns one negedge after the accept edge.
    task automatic offer(input int x, input bit push, input int expd, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = WIDTH'(x);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, int'(in_ready), 1);
        if (in_ready) begin
            if (push) sb.push_back('{exp_ch, expd, cyc + ORDER + 2, tag});
            exp_ch++;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Frame edge coincident with in_valid: blocked that cycle, accepted next cycle as channel 0.
    task automatic edge_with_valid(input int x, input int expd, input string tag);
        @(negedge clk);
        lr_clk   = 1'b1;
        in_valid = 1'b1;
        in_data  = WIDTH'(x);
        #1 check({tag, "_blocked"}, int'(in_ready), 0);
        @(negedge clk);
        lr_clk = 1'b0;
        #1 check({tag, "_ready"}, int'(in_ready), 1);
        sb.push_back('{0, expd, cyc + ORDER + 2, tag});
        exp_ch = 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int sq_x  [5] = '{0, 1, 4, 9, 16};
        int sq_y  [5] = '{0, 1, 1, 0, 0};
        int imp_x [5] = '{100, 0, 0, 0, 0};
        int imp_y [5] = '{100, -300, 300, -100, 0};
        int seen;
        int e;

        zero_model();
        #3 rst_n = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Squares on channel 0, one per frame.
        for (int i = 0; i < 5; i++) begin
            frame();
            offer(sq_x[i], 1'b1, sq_y[i], "square");
            drain();
        end

        // Impulse from cleared history.
        clear_hist();
        for (int i = 0; i < 5; i++) begin
            frame();
            offer(imp_x[i], 1'b1, imp_y[i], "impulse");
            drain();
        end

        // Full-scale step: wraps or clamps depending on build.
        clear_hist();
        frame();
        offer(262143, 1'b1, 262143, "sat_first");
        drain();
        frame();
        offer(-262144, 1'b1, SAT2, "sat_second");
        drain();

        // Channel isolation across two frames, then a held-off 17th sample.
        clear_hist();
        frame();
        for (int c = 0; c < NUM_CH; c++) begin
            e = model(c, c * 10);
            offer(c * 10, 1'b1, e, "chan_f1");
        end
        drain();
        frame();
        for (int c = 0; c < NUM_CH; c++) begin
            e = model(c, c * 11);
            offer(c * 11, 1'b1, e, "chan_f2");
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = WIDTH'(123);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (in_ready) seen++;
        end
        check("chan17_held_off", seen, 0);
        e = model(0, 123);
        edge_with_valid(123, e, "chan17_next_frame");
        drain();

        // Coincident frame edge with a partly used frame.
        frame();
        e = model(0, 5);
        offer(5, 1'b1, e, "coinc_pre");
        drain();
        e = model(0, 9);
        edge_with_valid(9, e, "coinc");
        drain();

        // hist_clr during CALC.
        clear_hist();
        frame();
        offer(50, 1'b1, 50, "hclr_seed");
        drain();
        frame();
        offer(7, 1'b1, -143, "hclr_inflight");
        hist_clr = 1'b1;
        @(negedge clk);
        hist_clr = 1'b0;
        drain();
        frame();
        offer(7, 1'b1, 7, "hclr_after");
        drain();

        // Reset pulsed mid-CALC aborts the sample.
        frame();
        offer(33, 1'b0, 0, "rst_mid");
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", int'(out_valid), 0);
        check("rst_mid_out_data", int'(out_data), 0);
        check("rst_mid_out_ch", int'(out_ch), 0);
        check("rst_mid_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        zero_model();
        repeat (10) @(negedge clk);
        frame();
        offer(20, 1'b1, 20, "post_rst");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
